decode: RTL and testbench

Second pipeline stage. It takes the fetched instruction word and PC from the IF/ID register, decodes RV32I base instructions, reads the 32×32 register file, generates the immediate, and detects load-use hazards. Results go to a registered ID/EX boundary that feeds execute. The block also owns the register file write port driven by writeback, and returns a stall request to fetch.

---
 rtl/decode.sv | 272 +++++++++++++++++++++++++++
 tb/tb_decode.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode
//
// Instruction decode stage of a five-stage RV32I pipeline. The instruction
// word and PC from the IF/ID register are decoded, the register file is read
// (with write-through from writeback), the immediate is generated and a
// load-use hazard against the instruction sitting in ID/EX is detected. The
// decoded fields are registered into the ID/EX boundary feeding execute.
//
// Ports
//   CLK             clock, all state updates on the rising edge
//   RES             asynchronous active-high reset
//   IF_ID_pc        PC of the instruction being decoded
//   IF_ID_inst      instruction word (32'h0 and unknown opcodes are bubbles)
//   branch_taken    redirect from execute; decode holds a wrong-path word
//   WB_we           register file write enable from writeback
//   WB_rd           register file write address
//   WB_data         register file write data
//   ID_stall        combinational stall request to fetch
//   ID_EX_valid     ID/EX holds a real instruction
//   ID_EX_pc        PC of the instruction in ID/EX
//   ID_EX_rs1_val   rs1 operand value
//   ID_EX_rs2_val   rs2 operand value
//   ID_EX_imm       sign-extended immediate
//   ID_EX_rs1       rs1 index
//   ID_EX_rs2       rs2 index
//   ID_EX_rd        rd index
//   ID_EX_opcode    opcode field
//   ID_EX_funct3    funct3 field
//   ID_EX_funct7b5  inst[30]
//   ID_EX_reg_we    instruction writes a non-zero rd
//   ID_EX_mem_re    instruction is a load
//   ID_EX_mem_we    instruction is a store
// ---------------------------------------------------------------------------
module decode (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] IF_ID_pc,
    input  logic [31:0] IF_ID_inst,
    input  logic        branch_taken,
    input  logic        WB_we,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    output logic        ID_stall,
    output logic        ID_EX_valid,
    output logic [31:0] ID_EX_pc,
    output logic [31:0] ID_EX_rs1_val,
    output logic [31:0] ID_EX_rs2_val,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [4:0]  ID_EX_rd,
    output logic [6:0]  ID_EX_opcode,
    output logic [2:0]  ID_EX_funct3,
    output logic        ID_EX_funct7b5,
    output logic        ID_EX_reg_we,
    output logic        ID_EX_mem_re,
    output logic        ID_EX_mem_we
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign opcode = IF_ID_inst[6:0];
    assign rd     = IF_ID_inst[11:7];
    assign funct3 = IF_ID_inst[14:12];
    assign rs1    = IF_ID_inst[19:15];
    assign rs2    = IF_ID_inst[24:20];

    // Immediate candidates, one per instruction format
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:20]};
    assign imm_s = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:25], IF_ID_inst[11:7]};
    assign imm_b = {{19{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[7],
                    IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0};
    assign imm_u = {IF_ID_inst[31:12], 12'h000};
    assign imm_j = {{11{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[19:12],
                    IF_ID_inst[20], IF_ID_inst[30:21], 1'b0};

    // Opcode classification
    logic        is_known;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic        is_load;
    logic        is_store;
    logic [31:0] imm;

    always_comb begin
        is_known  = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        imm       = 32'h0;
        case (opcode)
            OP_R: begin
                is_known  = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_I_ALU: begin
                is_known  = 1'b1;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OP_LOAD: begin
                is_known  = 1'b1;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
                imm       = imm_i;
            end
            OP_STORE: begin
                is_known  = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                is_store  = 1'b1;
                imm       = imm_s;
            end
            OP_BRANCH: begin
                is_known  = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm       = imm_b;
            end
            OP_JAL: begin
                is_known  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_j;
            end
            OP_JALR: begin
                is_known  = 1'b1;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                is_known  = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_u;
            end
            default: begin
                is_known  = 1'b0;
            end
        endcase
    end

    // Register file; x0 is never written and is masked on read
    logic [31:0] regs [32];

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (WB_we && (WB_rd != 5'd0)) begin
            regs[WB_rd] <= WB_data;
        end
    end

    // Write-through: a register being written this cycle reads the new value
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        if (rs1 == 5'd0) begin
            rs1_val = 32'h0;
        end else if (WB_we && (WB_rd == rs1)) begin
            rs1_val = WB_data;
        end else begin
            rs1_val = regs[rs1];
        end
    end

    always_comb begin
        if (rs2 == 5'd0) begin
            rs2_val = 32'h0;
        end else if (WB_we && (WB_rd == rs2)) begin
            rs2_val = WB_data;
        end else begin
            rs2_val = regs[rs2];
        end
    end

    // Load-use: the load in ID/EX produces its data too late for the
    // instruction in decode, so only register fields that are actually read
    // are allowed to raise the hazard.
    logic load_use;
    logic load_bubble;

    assign load_use = ID_EX_valid && ID_EX_mem_re && (ID_EX_rd != 5'd0) &&
                      ((use_rs1 && (rs1 == ID_EX_rd)) ||
                       (use_rs2 && (rs2 == ID_EX_rd)));

    // A redirect kills the instruction anyway, so there is nothing to hold
    assign ID_stall    = load_use && !branch_taken;
    assign load_bubble = branch_taken || ID_stall || !is_known;

    // ID/EX boundary register
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= 32'h0;
            ID_EX_rs1_val  <= 32'h0;
            ID_EX_rs2_val  <= 32'h0;
            ID_EX_imm      <= 32'h0;
            ID_EX_rs1      <= 5'd0;
            ID_EX_rs2      <= 5'd0;
            ID_EX_rd       <= 5'd0;
            ID_EX_opcode   <= 7'd0;
            ID_EX_funct3   <= 3'd0;
            ID_EX_funct7b5 <= 1'b0;
            ID_EX_reg_we   <= 1'b0;
            ID_EX_mem_re   <= 1'b0;
            ID_EX_mem_we   <= 1'b0;
        end else if (load_bubble) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= 32'h0;
            ID_EX_rs1_val  <= 32'h0;
            ID_EX_rs2_val  <= 32'h0;
            ID_EX_imm      <= 32'h0;
            ID_EX_rs1      <= 5'd0;
            ID_EX_rs2      <= 5'd0;
            ID_EX_rd       <= 5'd0;
            ID_EX_opcode   <= 7'd0;
            ID_EX_funct3   <= 3'd0;
            ID_EX_funct7b5 <= 1'b0;
            ID_EX_reg_we   <= 1'b0;
            ID_EX_mem_re   <= 1'b0;
            ID_EX_mem_we   <= 1'b0;
        end else begin
            ID_EX_valid    <= 1'b1;
            ID_EX_pc       <= IF_ID_pc;
            ID_EX_rs1_val  <= rs1_val;
            ID_EX_rs2_val  <= rs2_val;
            ID_EX_imm      <= imm;
            ID_EX_rs1      <= rs1;
            ID_EX_rs2      <= rs2;
            ID_EX_rd       <= rd;
            ID_EX_opcode   <= opcode;
            ID_EX_funct3   <= funct3;
            ID_EX_funct7b5 <= IF_ID_inst[30];
            ID_EX_reg_we   <= writes_rd && (rd != 5'd0);
            ID_EX_mem_re   <= is_load;
            ID_EX_mem_we   <= is_store;
        end
    end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode
//
// Self-checking bench for the decode stage: a directed vector table, a few
// hand-written reset sequences and a randomized run against a reference model.
// ---------------------------------------------------------------------------
module tb_decode;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        branch_taken;
    logic        WB_we;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic        ID_stall;
    logic        ID_EX_valid;
    logic [31:0] ID_EX_pc;
    logic [31:0] ID_EX_rs1_val;
    logic [31:0] ID_EX_rs2_val;
    logic [31:0] ID_EX_imm;
    logic [4:0]  ID_EX_rs1;
    logic [4:0]  ID_EX_rs2;
    logic [4:0]  ID_EX_rd;
    logic [6:0]  ID_EX_opcode;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7b5;
    logic        ID_EX_reg_we;
    logic        ID_EX_mem_re;
    logic        ID_EX_mem_we;

    decode dut (
        .CLK            (CLK),
        .RES            (RES),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_inst     (IF_ID_inst),
        .branch_taken   (branch_taken),
        .WB_we          (WB_we),
        .WB_rd          (WB_rd),
        .WB_data        (WB_data),
        .ID_stall       (ID_stall),
        .ID_EX_valid    (ID_EX_valid),
        .ID_EX_pc       (ID_EX_pc),
        .ID_EX_rs1_val  (ID_EX_rs1_val),
        .ID_EX_rs2_val  (ID_EX_rs2_val),
        .ID_EX_imm      (ID_EX_imm),
        .ID_EX_rs1      (ID_EX_rs1),
        .ID_EX_rs2      (ID_EX_rs2),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_opcode   (ID_EX_opcode),
        .ID_EX_funct3   (ID_EX_funct3),
        .ID_EX_funct7b5 (ID_EX_funct7b5),
        .ID_EX_reg_we   (ID_EX_reg_we),
        .ID_EX_mem_re   (ID_EX_mem_re),
        .ID_EX_mem_we   (ID_EX_mem_we)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } idex_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        bt;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [4:0]  exp_rd;
        logic [31:0] exp_imm;
        logic [31:0] exp_rs1_val;
        logic [31:0] exp_rs2_val;
        logic        exp_reg_we;
        logic        exp_mem_re;
        logic [6:0]  exp_opcode;
    } vec_t;

    idex_t dut_rec;
    assign dut_rec = {ID_EX_valid, ID_EX_pc, ID_EX_rs1_val, ID_EX_rs2_val, ID_EX_imm,
                      ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_opcode, ID_EX_funct3,
                      ID_EX_funct7b5, ID_EX_reg_we, ID_EX_mem_re, ID_EX_mem_we};

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] model_regs [32];
    idex_t       model_idex;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRecord(input string name, input idex_t act, input idex_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic wb_we, input logic [4:0] wb_rd,
                                 input logic [31:0] wb_data, input logic bt);
        @(negedge CLK);
        IF_ID_inst   = inst;
        IF_ID_pc     = pc;
        WB_we        = wb_we;
        WB_rd        = wb_rd;
        WB_data      = wb_data;
        branch_taken = bt;
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RES = 1'b1;
        repeat (2) @(negedge CLK);
        RES = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_idex = '0;
    endtask

    // Architectural view of a register read as seen by decode this cycle
    function automatic logic [31:0] modelRead(input logic [4:0] idx, input logic wb_we,
                                              input logic [4:0] wb_rd, input logic [31:0] wb_data);
        if (idx == 5'd0) return 32'h0;
        if (wb_we && wb_rd == idx) return wb_data;
        return model_regs[idx];
    endfunction

    // Next ID/EX contents and the stall request, from the instruction rules
    function automatic idex_t refDecode(input logic [31:0] inst, input logic [31:0] pc,
                                        input idex_t prev, input logic bt,
                                        input logic wb_we, input logic [4:0] wb_rd,
                                        input logic [31:0] wb_data, output logic stall);
        idex_t r;
        logic known, u1, u2, wr;
        logic [31:0] imm;
        int s;
        int hi;
        logic hazard;
        s     = int'(inst);
        known = 1'b1;
        u1    = 1'b0;
        u2    = 1'b0;
        wr    = 1'b0;
        imm   = 32'h0;
        case (inst[6:0])
            7'h33: begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
            7'h13, 7'h03, 7'h67: begin
                u1 = 1'b1; wr = 1'b1;
                hi = s >>> 20;
                imm = 32'(hi);
            end
            7'h23: begin
                u1 = 1'b1; u2 = 1'b1;
                hi = s >>> 25;
                imm = (32'(hi) << 5) | 32'(inst[11:7]);
            end
            7'h63: begin
                u1 = 1'b1; u2 = 1'b1;
                hi = s >>> 31;
                imm = (32'(hi) << 12) | (32'(inst[7]) << 11) |
                      (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            end
            7'h6F: begin
                wr = 1'b1;
                hi = s >>> 31;
                imm = (32'(hi) << 20) | (32'(inst[19:12]) << 12) |
                      (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            end
            7'h37, 7'h17: begin
                wr = 1'b1;
                imm = inst & 32'hFFFF_F000;
            end
            default: known = 1'b0;
        endcase
        hazard = prev.valid && prev.mem_re && prev.rd != 5'd0 &&
                 ((u1 && inst[19:15] == prev.rd) || (u2 && inst[24:20] == prev.rd));
        stall = hazard && !bt;
        if (bt || stall || !known) return '0;
        r.valid    = 1'b1;
        r.pc       = pc;
        r.rs1_val  = modelRead(inst[19:15], wb_we, wb_rd, wb_data);
        r.rs2_val  = modelRead(inst[24:20], wb_we, wb_rd, wb_data);
        r.imm      = imm;
        r.rs1      = inst[19:15];
        r.rs2      = inst[24:20];
        r.rd       = inst[11:7];
        r.opcode   = inst[6:0];
        r.funct3   = inst[14:12];
        r.funct7b5 = inst[30];
        r.reg_we   = wr && inst[11:7] != 5'd0;
        r.mem_re   = inst[6:0] == 7'h03;
        r.mem_we   = inst[6:0] == 7'h23;
        return r;
    endfunction

    vec_t vecs [11];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [6:0]  ops [9];
        logic [31:0] inst;
        logic [31:0] pc;
        logic        hold;
        logic        exp_stall;
        logic        bt;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        idex_t       exp_next;
        int          r;

        //         inst          pc            we    rd     data          bt    stall valid pc          rd     imm           rs1v          rs2v          rwe   mre   op
        vecs[0]  = '{32'h00500093, 32'h04, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h04, 5'd1,  32'h5,        32'h0,        32'h0,        1'b1, 1'b0, 7'h13};
        vecs[1]  = '{32'h00318233, 32'h08, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h08, 5'd4,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 7'h33};
        vecs[2]  = '{32'h000183B3, 32'h0C, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0C, 5'd7,  32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 7'h33};
        vecs[3]  = '{32'h0000A283, 32'h10, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10, 5'd5,  32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 7'h03};
        vecs[4]  = '{32'h00028333, 32'h14, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 7'h00};
        vecs[5]  = '{32'h00028333, 32'h14, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h14, 5'd6,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 7'h33};
        vecs[6]  = '{32'hFE000CE3, 32'h18, 1'b1, 5'd0, 32'h1234,     1'b0, 1'b0, 1'b1, 32'h18, 5'd25, 32'hFFFFFFF8, 32'h0,        32'h0,        1'b0, 1'b0, 7'h63};
        vecs[7]  = '{32'h00500093, 32'h1C, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 7'h00};
        vecs[8]  = '{32'h0000A283, 32'h20, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h20, 5'd5,  32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 7'h03};
        vecs[9]  = '{32'h00028333, 32'h24, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 7'h00};
        vecs[10] = '{32'h00028333, 32'h24, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h24, 5'd6,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 7'h33};

        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        RES          = 1'b1;
        IF_ID_inst   = 32'h0;
        IF_ID_pc     = 32'h0;
        branch_taken = 1'b0;
        WB_we        = 1'b0;
        WB_rd        = 5'd0;
        WB_data      = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("reset_valid", 32'(ID_EX_valid), 32'h0);
        checkOutput("reset_stall", 32'(ID_stall), 32'h0);
        checkRecord("reset_idex", dut_rec, '0);
        RES = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].inst, vecs[i].pc, vecs[i].wb_we, vecs[i].wb_rd,
                          vecs[i].wb_data, vecs[i].bt);
            #1;
            checkOutput($sformatf("v%0d_stall", i), 32'(ID_stall), 32'(vecs[i].exp_stall));
            @(posedge CLK);
            #1;
            checkOutput($sformatf("v%0d_valid", i), 32'(ID_EX_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d_pc", i), ID_EX_pc, vecs[i].exp_pc);
            checkOutput($sformatf("v%0d_rd", i), 32'(ID_EX_rd), 32'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d_imm", i), ID_EX_imm, vecs[i].exp_imm);
            checkOutput($sformatf("v%0d_rs1_val", i), ID_EX_rs1_val, vecs[i].exp_rs1_val);
            checkOutput($sformatf("v%0d_rs2_val", i), ID_EX_rs2_val, vecs[i].exp_rs2_val);
            checkOutput($sformatf("v%0d_reg_we", i), 32'(ID_EX_reg_we), 32'(vecs[i].exp_reg_we));
            checkOutput($sformatf("v%0d_mem_re", i), 32'(ID_EX_mem_re), 32'(vecs[i].exp_mem_re));
            checkOutput($sformatf("v%0d_opcode", i), 32'(ID_EX_opcode), 32'(vecs[i].exp_opcode));
        end

        // Asynchronous reset in the middle of a load-use stall
        applyStimulus(32'h0000A283, 32'h30, 1'b0, 5'd0, 32'h0, 1'b0);
        @(posedge CLK);
        applyStimulus(32'h00028333, 32'h34, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        checkOutput("midstall_stall_before", 32'(ID_stall), 32'h1);
        checkOutput("midstall_valid_before", 32'(ID_EX_valid), 32'h1);
        #1;
        RES = 1'b1;
        #1;
        checkOutput("async_stall", 32'(ID_stall), 32'h0);
        checkRecord("async_idex", dut_rec, '0);
        @(negedge CLK);
        RES = 1'b0;
        // x3 held DEADBEEF before reset and must now read back as zero
        applyStimulus(32'h00318233, 32'h38, 1'b0, 5'd0, 32'h0, 1'b0);
        @(posedge CLK);
        #1;
        checkOutput("postreset_valid", 32'(ID_EX_valid), 32'h1);
        checkOutput("postreset_rs1_val", ID_EX_rs1_val, 32'h0);
        checkOutput("postreset_rs2_val", ID_EX_rs2_val, 32'h0);

        // Randomized run against the reference model
        applyReset();
        hold = 1'b0;
        inst = 32'h0;
        pc   = 32'h0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!hold) begin
                r    = $urandom_range(0, 12);
                inst = $urandom;
                if (r < 9) inst[6:0] = ops[r];
                else if (r < 11) inst[6:0] = 7'h03;
                else if (r == 12) inst = 32'h0;
                inst[11:7]  = 5'($urandom_range(0, 7));
                inst[19:15] = 5'($urandom_range(0, 7));
                inst[24:20] = 5'($urandom_range(0, 7));
                pc = $urandom & 32'hFFFF_FFFC;
            end
            wb_we   = 1'($urandom_range(0, 1));
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            bt      = ($urandom_range(0, 9) == 0);
            applyStimulus(inst, pc, wb_we, wb_rd, wb_data, bt);
            exp_next = refDecode(inst, pc, model_idex, bt, wb_we, wb_rd, wb_data, exp_stall);
            #1;
            checkOutput("rand_stall", 32'(ID_stall), 32'(exp_stall));
            @(posedge CLK);
            #1;
            checkRecord("rand_idex", dut_rec, exp_next);
            model_idex = exp_next;
            if (wb_we && wb_rd != 5'd0) model_regs[wb_rd] = wb_data;
            hold = exp_stall;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
